// File: rtl/mmio_uart_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : mmio_uart_fifo
//  Description : Memory-mapped UART bridge with TX/RX FIFOs, a status/control
//                register set and sticky error flags. Sits between the core's
//                EX/MEM data port and the UART PHY. Read data is
//                combinational so the MEM/WB register can sample it in the
//                same cycle as the access.
//  Register map (byte offsets from BASE_ADDR, word aligned only):
//      +0 DATA   W: push TX byte   R: pop RX byte ({24'b0, head}, 0 if empty)
//      +4 STATUS R: [0] rx_valid [1] tx_full [2] tx_empty [3] rx_full
//                   [4] tx_drop  [5] rx_underflow [15:8] tx_count
//                   [23:16] rx_count
//      +8 CTRL   W: [0] clear error flags  [1] flush both FIFOs; reads 0
//      +C IE     R/W interrupt enables when MMIO_UART_IRQ_EN is defined,
//                otherwise reads 0 and ignores writes (irq tied 0)
//  Ports:
//      clk, rst            core clock, synchronous active-low reset
//      bus_*               MMIO data port (addr/rd/wr/wdata in, rdata/hit out)
//      uart_tx_*           byte + one-cycle push pulse to PHY, PHY busy in
//      uart_rx_*           PHY byte + valid in, one-cycle read ack out
//      irq                 registered level interrupt
//  Configuration macro : MMIO_UART_IRQ_EN
//  Revision    : 1.0  initial release
// ============================================================================
module mmio_uart_fifo #(
    parameter logic [31:0] BASE_ADDR = 32'h1000_0000,
    parameter int          TX_DEPTH  = 16,
    parameter int          RX_DEPTH  = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] bus_addr,
    input  logic        bus_rd,
    input  logic        bus_wr,
    input  logic [31:0] bus_wdata,
    output logic [31:0] bus_rdata,
    output logic        bus_hit,
    output logic [7:0]  uart_tx_data_out,
    output logic        uart_tx_we_out,
    input  logic        uart_tx_busy_in,
    input  logic [7:0]  uart_rx_data_in,
    input  logic        uart_rx_valid_in,
    output logic        uart_rx_re_out,
    output logic        irq
);

    localparam int c_TX_AW = $clog2(TX_DEPTH);
    localparam int c_TX_CW = c_TX_AW + 1;
    localparam int c_RX_AW = $clog2(RX_DEPTH);
    localparam int c_RX_CW = c_RX_AW + 1;

    localparam logic [c_TX_CW-1:0] c_TX_FULL = TX_DEPTH[c_TX_CW-1:0];
    localparam logic [c_RX_CW-1:0] c_RX_FULL = RX_DEPTH[c_RX_CW-1:0];

    localparam logic [1:0] c_REG_DATA   = 2'd0;
    localparam logic [1:0] c_REG_STATUS = 2'd1;
    localparam logic [1:0] c_REG_CTRL   = 2'd2;
    localparam logic [1:0] c_REG_IE     = 2'd3;

    typedef enum logic [1:0] {
        T_IDLE  = 2'd0,
        T_PULSE = 2'd1,
        T_GAP   = 2'd2
    } tx_state_t;

    typedef enum logic [1:0] {
        R_IDLE = 2'd0,
        R_ACK  = 2'd1,
        R_GAP  = 2'd2
    } rx_state_t;

    // ------------------------------------------------------------------
    // Address decode
    // ------------------------------------------------------------------
    logic [31:0] w_off;
    logic        w_hit;
    logic [1:0]  w_sel;
    logic        w_data_wr;
    logic        w_data_rd;
    logic        w_ctrl_wr;
    logic        w_flush;
    logic        w_clr;

    // Subtracting the base lets addresses below BASE_ADDR wrap to a large
    // offset, so a single upper-bits check covers both range limits.
    assign w_off     = bus_addr - BASE_ADDR;
    assign w_hit     = (w_off[31:4] == 28'd0) && (w_off[1:0] == 2'b00);
    assign w_sel     = w_off[3:2];
    assign bus_hit   = w_hit;

    assign w_data_wr = w_hit && bus_wr && (w_sel == c_REG_DATA);
    assign w_data_rd = w_hit && bus_rd && (w_sel == c_REG_DATA);
    assign w_ctrl_wr = w_hit && bus_wr && (w_sel == c_REG_CTRL);
    assign w_flush   = w_ctrl_wr && bus_wdata[1];
    assign w_clr     = w_ctrl_wr && bus_wdata[0];

    // Only the low byte of a store carries information for this block.
    logic w_unused_wdata;
    assign w_unused_wdata = &{1'b0, bus_wdata[31:8]};

    // ------------------------------------------------------------------
    // TX FIFO
    // ------------------------------------------------------------------
    logic [7:0]         r_tx_mem [TX_DEPTH];
    logic [c_TX_AW-1:0] r_tx_wptr;
    logic [c_TX_AW-1:0] r_tx_rptr;
    logic [c_TX_CW-1:0] r_tx_count;
    logic               w_tx_full;
    logic               w_tx_empty;
    logic               w_tx_push;
    logic               w_tx_pop;
    logic               w_tx_drop;

    tx_state_t r_tx_state;
    tx_state_t w_tx_state_nxt;
    logic      w_tx_start;
    logic [7:0] r_tx_data;

    assign w_tx_full  = (r_tx_count == c_TX_FULL);
    assign w_tx_empty = (r_tx_count == '0);
    // Fullness is judged on the registered count, so a store into a full
    // FIFO is dropped even when the drain pops in the same cycle.
    assign w_tx_push  = w_data_wr && !w_tx_full;
    assign w_tx_drop  = w_data_wr && w_tx_full;
    assign w_tx_pop   = (r_tx_state == T_PULSE) && !w_tx_empty;

    always_ff @(posedge clk) begin
        if (!rst || w_flush) begin
            r_tx_wptr  <= '0;
            r_tx_rptr  <= '0;
            r_tx_count <= '0;
        end else begin
            if (w_tx_push) r_tx_wptr <= r_tx_wptr + c_TX_AW'(1);
            if (w_tx_pop)  r_tx_rptr <= r_tx_rptr + c_TX_AW'(1);
            case ({w_tx_push, w_tx_pop})
                2'b10:   r_tx_count <= r_tx_count + c_TX_CW'(1);
                2'b01:   r_tx_count <= r_tx_count - c_TX_CW'(1);
                default: r_tx_count <= r_tx_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_tx_push) r_tx_mem[r_tx_wptr] <= bus_wdata[7:0];
    end

    // ------------------------------------------------------------------
    // TX drain FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst) r_tx_state <= T_IDLE;
        else      r_tx_state <= w_tx_state_nxt;
    end

    always_comb begin
        w_tx_state_nxt = r_tx_state;
        w_tx_start     = 1'b0;
        uart_tx_we_out = 1'b0;
        case (r_tx_state)
            T_IDLE: begin
                // A flush in the same cycle would empty the FIFO under us.
                if (!w_tx_empty && !uart_tx_busy_in && !w_flush) begin
                    w_tx_state_nxt = T_PULSE;
                    w_tx_start     = 1'b1;
                end
            end
            T_PULSE: begin
                // Gated by rst so a reset cycle never emits a pulse.
                uart_tx_we_out = rst;
                w_tx_state_nxt = T_GAP;
            end
            T_GAP:   w_tx_state_nxt = T_IDLE;
            default: w_tx_state_nxt = T_IDLE;
        endcase
    end

    // Head byte is captured on entry to T_PULSE and held afterwards.
    always_ff @(posedge clk) begin
        if (!rst)            r_tx_data <= 8'd0;
        else if (w_tx_start) r_tx_data <= r_tx_mem[r_tx_rptr];
    end
    assign uart_tx_data_out = r_tx_data;

    // ------------------------------------------------------------------
    // RX FIFO
    // ------------------------------------------------------------------
    logic [7:0]         r_rx_mem [RX_DEPTH];
    logic [c_RX_AW-1:0] r_rx_wptr;
    logic [c_RX_AW-1:0] r_rx_rptr;
    logic [c_RX_CW-1:0] r_rx_count;
    logic               w_rx_full;
    logic               w_rx_empty;
    logic               w_rx_push;
    logic               w_rx_pop;
    logic               w_rx_uflow;

    rx_state_t r_rx_state;
    rx_state_t w_rx_state_nxt;

    assign w_rx_full  = (r_rx_count == c_RX_FULL);
    assign w_rx_empty = (r_rx_count == '0);
    assign w_rx_push  = (r_rx_state == R_ACK) && !w_rx_full;
    assign w_rx_pop   = w_data_rd && !w_rx_empty;
    assign w_rx_uflow = w_data_rd && w_rx_empty;

    always_ff @(posedge clk) begin
        if (!rst || w_flush) begin
            r_rx_wptr  <= '0;
            r_rx_rptr  <= '0;
            r_rx_count <= '0;
        end else begin
            if (w_rx_push) r_rx_wptr <= r_rx_wptr + c_RX_AW'(1);
            if (w_rx_pop)  r_rx_rptr <= r_rx_rptr + c_RX_AW'(1);
            case ({w_rx_push, w_rx_pop})
                2'b10:   r_rx_count <= r_rx_count + c_RX_CW'(1);
                2'b01:   r_rx_count <= r_rx_count - c_RX_CW'(1);
                default: r_rx_count <= r_rx_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_rx_push) r_rx_mem[r_rx_wptr] <= uart_rx_data_in;
    end

    // ------------------------------------------------------------------
    // RX fill FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst) r_rx_state <= R_IDLE;
        else      r_rx_state <= w_rx_state_nxt;
    end

    always_comb begin
        w_rx_state_nxt = r_rx_state;
        uart_rx_re_out = 1'b0;
        case (r_rx_state)
            R_IDLE: begin
                // With RX full the byte simply waits in the PHY.
                if (uart_rx_valid_in && !w_rx_full) w_rx_state_nxt = R_ACK;
            end
            R_ACK: begin
                uart_rx_re_out = rst;
                w_rx_state_nxt = R_GAP;
            end
            R_GAP:   w_rx_state_nxt = R_IDLE;
            default: w_rx_state_nxt = R_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Sticky error flags
    // ------------------------------------------------------------------
    logic r_tx_drop;
    logic r_rx_uflow;

    // Clear and set come from different register offsets, so they never
    // coincide; clear is listed first only for readability.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_tx_drop  <= 1'b0;
            r_rx_uflow <= 1'b0;
        end else if (w_clr) begin
            r_tx_drop  <= 1'b0;
            r_rx_uflow <= 1'b0;
        end else begin
            if (w_tx_drop)  r_tx_drop  <= 1'b1;
            if (w_rx_uflow) r_rx_uflow <= 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Interrupt enable and irq
    // ------------------------------------------------------------------
`ifdef MMIO_UART_IRQ_EN
    logic [2:0] r_ie;
    logic       r_irq;
    logic       w_ie_wr;

    assign w_ie_wr = w_hit && bus_wr && (w_sel == c_REG_IE);

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_ie  <= 3'd0;
            r_irq <= 1'b0;
        end else begin
            if (w_ie_wr) r_ie <= bus_wdata[2:0];
            r_irq <= |(r_ie & {r_tx_drop | r_rx_uflow, w_tx_empty, !w_rx_empty});
        end
    end
    assign irq = r_irq;
`else
    assign irq = 1'b0;
`endif

    // ------------------------------------------------------------------
    // Combinational read mux
    // ------------------------------------------------------------------
    logic [7:0] w_tx_count8;
    logic [7:0] w_rx_count8;

    assign w_tx_count8 = 8'(r_tx_count);
    assign w_rx_count8 = 8'(r_rx_count);

    always_comb begin
        bus_rdata = 32'd0;
        if (w_hit) begin
            case (w_sel)
                c_REG_DATA: begin
                    if (!w_rx_empty) bus_rdata = {24'd0, r_rx_mem[r_rx_rptr]};
                end
                c_REG_STATUS: begin
                    bus_rdata = {8'd0, w_rx_count8, w_tx_count8, 2'b00,
                                 r_rx_uflow, r_tx_drop, w_rx_full,
                                 w_tx_empty, w_tx_full, !w_rx_empty};
                end
                c_REG_CTRL: bus_rdata = 32'd0;
                c_REG_IE: begin
`ifdef MMIO_UART_IRQ_EN
                    bus_rdata = {29'd0, r_ie};
`else
                    bus_rdata = 32'd0;
`endif
                end
                default: bus_rdata = 32'd0;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mmio_uart_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mmio_uart_fifo
//  Description : Self-checking bench for mmio_uart_fifo. A queue-based model
//                tracks FIFO contents and flags and is compared against the
//                DUT every cycle; directed sequences add literal checks.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_mmio_uart_fifo;

    localparam logic [31:0] c_BASE = 32'h1000_0000;
    localparam int          c_TXD  = 16;
    localparam int          c_RXD  = 16;
    localparam logic [31:0] c_A_DATA = c_BASE;
    localparam logic [31:0] c_A_STAT = c_BASE + 32'd4;
    localparam logic [31:0] c_A_CTRL = c_BASE + 32'd8;
    localparam logic [31:0] c_A_IE   = c_BASE + 32'd12;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] bus_addr = 32'd0;
    logic        bus_rd = 1'b0;
    logic        bus_wr = 1'b0;
    logic [31:0] bus_wdata = 32'd0;
    logic [31:0] bus_rdata;
    logic        bus_hit;
    logic [7:0]  uart_tx_data_out;
    logic        uart_tx_we_out;
    logic        uart_tx_busy_in = 1'b0;
    logic [7:0]  uart_rx_data_in = 8'd0;
    logic        uart_rx_valid_in = 1'b0;
    logic        uart_rx_re_out;
    logic        irq;

    always #5 clk = ~clk;

    mmio_uart_fifo #(
        .BASE_ADDR(c_BASE),
        .TX_DEPTH (c_TXD),
        .RX_DEPTH (c_RXD)
    ) u_dut (
        .clk             (clk),
        .rst             (rst),
        .bus_addr        (bus_addr),
        .bus_rd          (bus_rd),
        .bus_wr          (bus_wr),
        .bus_wdata       (bus_wdata),
        .bus_rdata       (bus_rdata),
        .bus_hit         (bus_hit),
        .uart_tx_data_out(uart_tx_data_out),
        .uart_tx_we_out  (uart_tx_we_out),
        .uart_tx_busy_in (uart_tx_busy_in),
        .uart_rx_data_in (uart_rx_data_in),
        .uart_rx_valid_in(uart_rx_valid_in),
        .uart_rx_re_out  (uart_rx_re_out),
        .irq             (irq)
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // ------------------------------------------------------------------
    // Behavioural model
    // ------------------------------------------------------------------
    logic [7:0] tx_q[$];
    logic [7:0] rx_q[$];
    logic [7:0] seen_tx[$];
    int         re_count = 0;
    logic       m_drop = 1'b0;
    logic       m_uf   = 1'b0;
    logic [2:0] m_ie   = 3'd0;
    logic       m_irq  = 1'b0;
    logic [7:0] m_data = 8'd0;
    logic       prev_busy = 1'b0;
    logic       prev_rxv  = 1'b0;
    int         cyc = 0;
    int         last_we = -100;

    logic [31:0] c_off;
    logic        c_hit;
    logic        c_full;
    logic        c_irqn;

    function automatic logic [31:0] m_status();
        logic [31:0] s;
        s        = 32'd0;
        s[0]     = (rx_q.size() != 0);
        s[1]     = (tx_q.size() == c_TXD);
        s[2]     = (tx_q.size() == 0);
        s[3]     = (rx_q.size() == c_RXD);
        s[4]     = m_drop;
        s[5]     = m_uf;
        s[15:8]  = 8'(tx_q.size());
        s[23:16] = 8'(rx_q.size());
        return s;
    endfunction

    function automatic logic [31:0] exp_read(input logic [31:0] off, input logic hit);
        logic [31:0] v;
        v = 32'd0;
        if (hit) begin
            case (off[3:2])
                2'd0: if (rx_q.size() != 0) v = {24'd0, rx_q[0]};
                2'd1: v = m_status();
                2'd2: v = 32'd0;
                default: begin
`ifdef MMIO_UART_IRQ_EN
                    v = {29'd0, m_ie};
`else
                    v = 32'd0;
`endif
                end
            endcase
        end
        return v;
    endfunction

    always @(negedge clk) begin
        cyc++;
        if (!rst) begin
            chk("we_in_reset", uart_tx_we_out, 0);
            chk("re_in_reset", uart_rx_re_out, 0);
            tx_q.delete();
            rx_q.delete();
            m_drop = 1'b0;
            m_uf   = 1'b0;
            m_ie   = 3'd0;
            m_irq  = 1'b0;
            m_data = 8'd0;
        end else begin
            c_off = bus_addr - c_BASE;
            c_hit = (c_off < 32'd16) && (c_off[1:0] == 2'b00);
            chk("hit", bus_hit, c_hit);
            if (!c_hit || bus_rd) chk("rdata", bus_rdata, exp_read(c_off, c_hit));

            if (uart_tx_we_out) begin
                chk("tx_pulse_fifo_empty", (tx_q.size() == 0), 0);
                if (tx_q.size() != 0) begin
                    chk("tx_byte", uart_tx_data_out, tx_q[0]);
                    m_data = tx_q[0];
                end
                chk("tx_pulse_after_busy", prev_busy, 0);
                chk("tx_pulse_spacing_ok", ((cyc - last_we) >= 2), 1);
                seen_tx.push_back(uart_tx_data_out);
                last_we = cyc;
            end else begin
                chk("tx_data_hold", uart_tx_data_out, m_data);
            end

            if (uart_rx_re_out) begin
                chk("rx_ack_without_valid", prev_rxv, 1);
                chk("rx_ack_room", (rx_q.size() < c_RXD), 1);
                re_count++;
            end

`ifdef MMIO_UART_IRQ_EN
            chk("irq", irq, m_irq);
`else
            chk("irq_tied", irq, 0);
`endif

            // Next-state of the model
            c_irqn = |(m_ie & {m_drop | m_uf, (tx_q.size() == 0), (rx_q.size() != 0)});
            c_full = (tx_q.size() == c_TXD);
            if (uart_tx_we_out && tx_q.size() != 0) void'(tx_q.pop_front());
            if (c_hit && bus_wr && c_off[3:2] == 2'd0) begin
                if (c_full) m_drop = 1'b1;
                else        tx_q.push_back(bus_wdata[7:0]);
            end
            if (c_hit && bus_rd && c_off[3:2] == 2'd0) begin
                if (rx_q.size() != 0) void'(rx_q.pop_front());
                else                  m_uf = 1'b1;
            end
            if (uart_rx_re_out) rx_q.push_back(uart_rx_data_in);
            if (c_hit && bus_wr && c_off[3:2] == 2'd2) begin
                if (bus_wdata[0]) begin
                    m_drop = 1'b0;
                    m_uf   = 1'b0;
                end
                if (bus_wdata[1]) begin
                    tx_q.delete();
                    rx_q.delete();
                end
            end
`ifdef MMIO_UART_IRQ_EN
            if (c_hit && bus_wr && c_off[3:2] == 2'd3) m_ie = bus_wdata[2:0];
`endif
            m_irq = c_irqn;
        end
        prev_busy = uart_tx_busy_in;
        prev_rxv  = uart_rx_valid_in;
    end

    // ------------------------------------------------------------------
    // Stimulus helpers
    // ------------------------------------------------------------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
        bus_addr  = a;
        bus_wdata = d;
        bus_wr    = 1'b1;
        tick();
        bus_wr    = 1'b0;
        bus_addr  = 32'd0;
        bus_wdata = 32'd0;
    endtask

    task automatic bus_read(input logic [31:0] a, output logic [31:0] d);
        bus_addr = a;
        bus_rd   = 1'b1;
        @(negedge clk);
        d = bus_rdata;
        tick();
        bus_rd   = 1'b0;
        bus_addr = 32'd0;
    endtask

    task automatic wait_tx(input int n, input int budget);
        for (int i = 0; i < budget && seen_tx.size() < n; i++) tick();
        chk("tx_pulse_count", seen_tx.size(), n);
    endtask

    // Presents one byte until it is acknowledged, then returns with the RX
    // FSM back in its idle state.
    task automatic rx_byte(input logic [7:0] b);
        int target;
        target           = re_count + 1;
        uart_rx_data_in  = b;
        uart_rx_valid_in = 1'b1;
        for (int i = 0; i < 20 && re_count < target; i++) tick();
        chk("rx_ack_count", re_count, target);
        uart_rx_valid_in = 1'b0;
        tick();
    endtask

    // ------------------------------------------------------------------
    // Directed sequences
    // ------------------------------------------------------------------
    logic [31:0] r;
    logic        re_now;
    int          base_n;

    initial begin
        repeat (3) tick();
        rst = 1'b1;
        tick();

        // 1. reset state
        bus_read(c_A_STAT, r);
        chk("status_after_reset", r, 32'h0000_0004);
        chk("we_after_reset", uart_tx_we_out, 0);
        chk("re_after_reset", uart_rx_re_out, 0);

        // 2. three bytes drain in order; busy blocks further pulses
        bus_write(c_A_DATA, 32'h41);
        bus_write(c_A_DATA, 32'h42);
        bus_write(c_A_DATA, 32'h43);
        wait_tx(3, 40);
        chk("tx_seq0", seen_tx[0], 8'h41);
        chk("tx_seq1", seen_tx[1], 8'h42);
        chk("tx_seq2", seen_tx[2], 8'h43);
        uart_tx_busy_in = 1'b1;
        bus_write(c_A_DATA, 32'h44);
        repeat (10) tick();
        chk("no_pulse_while_busy", seen_tx.size(), 3);
        uart_tx_busy_in = 1'b0;
        wait_tx(4, 20);
        chk("tx_after_busy", seen_tx[3], 8'h44);

        // 3. overfill, clear flag, drain without the dropped byte
        uart_tx_busy_in = 1'b1;
        for (int i = 0; i < 16; i++) bus_write(c_A_DATA, 32'h10 + i);
        bus_write(c_A_DATA, 32'h99);
        bus_read(c_A_STAT, r);
        chk("status_full_drop", r, 32'h0000_1012);
        bus_write(c_A_CTRL, 32'h1);
        bus_read(c_A_STAT, r);
        chk("status_drop_cleared", r, 32'h0000_1002);
        uart_tx_busy_in = 1'b0;
        wait_tx(20, 200);
        for (int i = 0; i < 16; i++) chk("tx_full_drain", seen_tx[4 + i], 8'h10 + i);
        repeat (10) tick();
        chk("dropped_byte_absent", seen_tx.size(), 20);

        // 4. RX receive, read, underflow
        rx_byte(8'h5A);
        bus_read(c_A_STAT, r);
        chk("status_rx_one", r, 32'h0001_0005);
        bus_read(c_A_DATA, r);
        chk("rx_data", r, 32'h5A);
        bus_read(c_A_STAT, r);
        chk("status_rx_empty", r, 32'h0000_0004);
        bus_read(c_A_DATA, r);
        chk("rx_empty_read", r, 32'h0);
        bus_read(c_A_STAT, r);
        chk("status_underflow", r, 32'h0000_0024);
        bus_write(c_A_CTRL, 32'h1);

        // Unaligned / out-of-range accesses have no effect
        bus_read(c_BASE + 32'd1, r);
        chk("unaligned_read", r, 32'h0);
        uart_tx_busy_in = 1'b1;
        bus_write(c_BASE + 32'd2, 32'h55);
        bus_read(c_BASE + 32'd16, r);
        chk("out_of_range_read", r, 32'h0);
        bus_read(c_A_STAT, r);
        chk("status_after_bad_addr", r, 32'h0000_0004);

        // 5. simultaneous RX push and DATA pop
        rx_byte(8'h11);
        uart_rx_data_in  = 8'h22;
        uart_rx_valid_in = 1'b1;
        tick();
        bus_addr = c_A_DATA;
        bus_rd   = 1'b1;
        @(negedge clk);
        r      = bus_rdata;
        re_now = uart_rx_re_out;
        tick();
        bus_rd           = 1'b0;
        bus_addr         = 32'd0;
        uart_rx_valid_in = 1'b0;
        chk("coincident_read", r, 32'h11);
        chk("coincident_ack", re_now, 1);
        bus_read(c_A_STAT, r);
        chk("status_count_kept", r, 32'h0001_0005);
        bus_read(c_A_DATA, r);
        chk("rx_order", r, 32'h22);

        // flush both FIFOs
        bus_write(c_A_DATA, 32'h61);
        bus_write(c_A_DATA, 32'h62);
        bus_write(c_A_DATA, 32'h63);
        rx_byte(8'h33);
        bus_write(c_A_CTRL, 32'h2);
        bus_read(c_A_STAT, r);
        chk("status_after_flush", r, 32'h0000_0004);

        // reset during drain
        for (int i = 0; i < 4; i++) bus_write(c_A_DATA, 32'hA0 + i);
        base_n = seen_tx.size();
        uart_tx_busy_in = 1'b0;
        wait_tx(base_n + 1, 20);
        repeat (2) tick();
        rst = 1'b0;
        repeat (2) tick();
        rst = 1'b1;
        bus_read(c_A_STAT, r);
        chk("status_after_midreset", r, 32'h0000_0004);
        repeat (10) tick();
        chk("no_pulse_after_reset", seen_tx.size(), base_n + 1);

        // 6. interrupt
        bus_write(c_A_IE, 32'h1);
        bus_read(c_A_IE, r);
`ifdef MMIO_UART_IRQ_EN
        chk("ie_readback", r, 32'h1);
`else
        chk("ie_reads_zero", r, 32'h0);
`endif
        rx_byte(8'h77);
        @(negedge clk);
`ifdef MMIO_UART_IRQ_EN
        chk("irq_after_rx", irq, 1);
`else
        chk("irq_after_rx", irq, 0);
`endif
        tick();
        bus_read(c_A_DATA, r);
        chk("irq_rx_data", r, 32'h77);
        tick();
        @(negedge clk);
        chk("irq_after_read", irq, 0);
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
